uart_tx: RTL and testbench
==========================

# uart_tx

Serial transmitter that drains the byte queue and sends each byte as an 8N1 UART frame toward the host link. It is the reader end of the queue's load/pop interface. It watches the queue's empty flag and reads its combinational head word. It issues exactly one pop pulse per byte accepted, then serializes that byte LSB-first on `tx`.

## Interface
- `NBITS`, default 8: data bits per frame; equals the queue word width.
- `CLKS_PER_BIT`, default 434: clock cycles per serial bit (50 MHz / 115200). Legal range 2 .. 2^CNTBITS.
- `CNTBITS`, default 9: width of the bit-period counter.
- `ck`: input, 1 bit. Single clock; all state updates on its rising edge.
- `rst`: input, 1 bit. Reset is synchronous and active-low, sampled on the rising edge of `ck`.
- `em`: input, 1 bit. Queue empty flag; 1 = no data.
- `din`: input, NBITS bits. Queue head word; valid whenever `em` = 0.
- `en`: input, 1 bit. Transmit enable; 0 blocks the start of new frames only.
- `pp`: output, 1 bit. Pop request to the queue; one-cycle pulse per accepted byte.
- `tx`: output, 1 bit. Serial line; idles high.
- `busy`: output, 1 bit. 1 while a frame is in progress.

## Operation
- The FSM has four states: IDLE, START, DATA, STOP. All outputs are registered.
- **Reset** (`rst` = 0 at an edge): state goes to IDLE. Outputs become `tx` = 1, `pp` = 0, `busy` = 0. The bit counter and bit index clear to 0, and the shift register clears to 0.
- **IDLE → START:** taken at an edge where `em` = 0 and `en` = 1. At that edge:
  - `din` is captured into the shift register.
  - `pp` is driven to 1 and `busy` to 1.
  - `tx` is driven to 0 (start bit) and the counter is cleared.
- **IDLE, otherwise:** `tx` = 1, `pp` = 0, `busy` = 0.
- **`pp` pulse:** `pp` is high for exactly one cycle, the cycle after the capture edge. It is forced to 0 in every state other than the IDLE→START transition.
- **START:** holds `tx` = 0 for CLKS_PER_BIT cycles, then moves to DATA with `tx` = shift[0] and bit index 0.
- **DATA:** each bit is held for CLKS_PER_BIT cycles. At the end of each bit the register shifts right and `tx` takes the next bit.
  - After bit NBITS-1 completes, the FSM moves to STOP with `tx` = 1.
- **STOP:** holds `tx` = 1 for CLKS_PER_BIT cycles, then returns to IDLE with `busy` = 0.
- **Counter:** counts 0 .. CLKS_PER_BIT-1 and wraps to 0 at each bit boundary; it never overflows CNTBITS.
- **`en` behaviour:** `en` is sampled only in IDLE. Deasserting it mid-frame has no effect on the current frame.
- **`em` and `din`:** both are ignored outside IDLE. Data loaded into the queue during a frame waits.

## Timing
- **Pop latency:** the capture edge is T. `pp` is high from T to T+1, and the queue advances its read pointer at edge T+1.
  - The FSM is in START at T+1, so the same word cannot be captured twice.
- **Frame length:** `tx` low from T for CLKS_PER_BIT cycles; data bits occupy the next NBITS×CLKS_PER_BIT cycles; the stop bit the next CLKS_PER_BIT cycles.
  - Total frame: (NBITS+2)×CLKS_PER_BIT cycles.
- **Back-to-back frames:**
  - The end of STOP returns the FSM to IDLE, with `tx` = 1 for at least one cycle.
  - If `em` = 0 and `en` = 1 at the next edge, the following start bit begins.
  - Minimum frame period is therefore (NBITS+2)×CLKS_PER_BIT + 1 cycles.
- **Reset mid-frame:** takes effect at the next edge.
  - `tx` = 1 and `busy` = 0 immediately after that edge; the frame is truncated.
  - The byte being sent has already been popped and is lost.
  - If reset lands in the `pp`-high cycle, `pp` drops to 0 at that edge; the queue is also in reset.
- **Empty queue:** with `em` = 1 the block stays in IDLE indefinitely with `tx` = 1 and `pp` never asserted.

## Test plan
- **Single byte:** CLKS_PER_BIT=4, reset, `en`=1; present `din`=0x55 with `em`=0, then `em`=1 after the pop.
  - `pp` high exactly 1 cycle.
  - `tx` is 0 for 4 cycles, then the bits 1,0,1,0,1,0,1,0 for 4 cycles each, then 1 for 4 cycles.
  - `busy` high for 40 cycles.
- **Back-to-back:** CLKS_PER_BIT=4; queue holds 0xA5 then 0x3C.
  - Two `pp` pulses 41 cycles apart.
  - Decoded frames 0xA5, 0x3C; exactly 1 idle-high cycle between the stop bit and the next start bit.
- **Empty:** `em`=1 for 200 cycles → `tx`=1, `pp`=0, `busy`=0 throughout.
- **Enable gating:** `em`=0, `en`=0 for 50 cycles → no `pp`, `tx`=1.
  - Raise `en` → start bit begins after the next edge.
  - Drop `en` mid-frame → frame completes unaltered.
- **Reset mid-frame:** assert `rst`=0 during data bit 3 of 0xFF.
  - After the next edge: `tx`=1, `busy`=0, `pp`=0.
  - After release with `em`=0: a new full frame starts with a fresh pop.
- **Reset values:** apply `rst`=0 for 3 cycles from an arbitrary state → `tx`=1, `pp`=0, `busy`=0 after the first edge.

Source files
------------

// File: rtl/uart_tx.sv
// 8N1 UART transmitter that drains a byte queue through its empty flag, head word and pop pulse.
// Each accepted byte gets one pop pulse and is then shifted out LSB-first on tx.
module uart_tx #(
  parameter int NBITS        = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int CNTBITS      = 9
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             em,
  input  logic [NBITS-1:0] din,
  input  logic             en,
  output logic             pp,
  output logic             tx,
  output logic             busy
);

  localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CNTBITS-1:0] LAST = CNTBITS'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0]      TOP  = IW'(NBITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state, state_nx;
  logic [CNTBITS-1:0] cnt, cnt_nx;
  logic [IW-1:0]      idx, idx_nx;
  logic [NBITS-1:0]   shift, shift_nx;
  logic               tx_nx, pp_nx, busy_nx;

  always_ff @(posedge ck) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      tx    <= 1'b1;
      pp    <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      shift <= shift_nx;
      tx    <= tx_nx;
      pp    <= pp_nx;
      busy  <= busy_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = (cnt == LAST) ? '0 : cnt + 1'b1;
    idx_nx   = idx;
    shift_nx = shift;
    tx_nx    = tx;
    pp_nx    = 1'b0;
    busy_nx  = 1'b1;
    case (state)
      IDLE: begin
        cnt_nx  = '0;
        tx_nx   = 1'b1;
        busy_nx = 1'b0;
        // Leaving IDLE on the capture edge is what guarantees a single pop per word.
        if (!em && en) begin
          state_nx = START;
          shift_nx = din;
          pp_nx    = 1'b1;
          busy_nx  = 1'b1;
          tx_nx    = 1'b0;
        end
      end
      START: begin
        if (cnt == LAST) begin
          state_nx = DATA;
          tx_nx    = shift[0];
          idx_nx   = '0;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          if (idx == TOP) begin
            state_nx = STOP;
            tx_nx    = 1'b1;
          end else begin
            shift_nx = shift >> 1;
            tx_nx    = shift_nx[0];
            idx_nx   = idx + 1'b1;
          end
        end
      end
      STOP: begin
        tx_nx = 1'b1;
        if (cnt == LAST) begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with CLKS_PER_BIT=4: a table of frames with hand-written
// expected line patterns, plus sequences for reset, empty queue and enable gating.
module tb_uart_tx;
  localparam int CPB = 4;
  localparam int FL  = 10 * CPB;

  logic       ck = 1'b0;
  logic       rst = 1'b0;
  logic       em = 1'b1;
  logic       en = 1'b0;
  logic [7:0] din = 8'h00;
  logic       pp, tx, busy;

  uart_tx #(.NBITS(8), .CLKS_PER_BIT(CPB), .CNTBITS(9)) dut (
    .ck(ck), .rst(rst), .em(em), .din(din), .en(en), .pp(pp), .tx(tx), .busy(busy)
  );

  always #5 ck = ~ck;

  typedef struct {
    logic [7:0] data;
    logic       next_em;
    logic [7:0] next_data;
    logic       drop_en;
    logic [9:0] frame;   // [0]=start, [8:1]=data LSB first, [9]=stop
    string      name;
  } vec_t;

  vec_t vecs[5];
  int total = 0, passed = 0, cyc = 0, last_pp = 0;

  task automatic step();
    @(posedge ck);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Entered just after the capture edge; leaves just after the first IDLE edge.
  task automatic check_frame(input vec_t v);
    logic [FL-1:0] got_tx, exp_tx, got_busy;
    int pps = 0;
    for (int k = 0; k < FL; k++) begin
      got_tx[k]   = tx;
      got_busy[k] = busy;
      exp_tx[k]   = v.frame[k / CPB];
      if (pp === 1'b1) pps++;
      if (k == 0) begin
        em  = v.next_em;
        din = v.next_data;
      end
      if (v.drop_en && k == 4 * CPB + 1) en = 1'b0;
      if (k < FL - 1) step();
    end
    chk({v.name, " tx"}, 64'(got_tx), 64'(exp_tx));
    chk({v.name, " busy"}, 64'(got_busy), {24'h0, {FL{1'b1}}});
    chk({v.name, " pp count"}, 64'(pps), 64'd1);
    step();
    chk({v.name, " idle tx"}, 64'(tx), 64'd1);
    chk({v.name, " idle busy"}, 64'(busy), 64'd0);
    chk({v.name, " idle pp"}, 64'(pp), 64'd0);
    en = 1'b1;
  endtask

  initial begin
    int   bad;
    logic chained;
    vec_t v;
    vecs[0] = '{8'h55, 1'b1, 8'h00, 1'b0, 10'b1010101010, "single_55"};
    vecs[1] = '{8'hA5, 1'b0, 8'h3C, 1'b0, 10'b1101001010, "b2b_A5"};
    vecs[2] = '{8'h3C, 1'b1, 8'h00, 1'b0, 10'b1001111000, "b2b_3C"};
    vecs[3] = '{8'hFF, 1'b1, 8'h00, 1'b1, 10'b1111111110, "en_drop_FF"};
    vecs[4] = '{8'h00, 1'b1, 8'h00, 1'b0, 10'b1000000000, "zero_00"};

    // Reset values
    rst = 1'b0; em = 1'b1; en = 1'b0;
    step();
    chk("reset tx", 64'(tx), 64'd1);
    chk("reset pp", 64'(pp), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    step(); step();
    rst = 1'b1; en = 1'b1;

    // Empty queue
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      if (tx !== 1'b1 || pp !== 1'b0 || busy !== 1'b0) bad++;
      step();
    end
    chk("empty idle", 64'(bad), 64'd0);

    // Frame table, with chained entries sent back-to-back
    chained = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (!chained) begin
        din = vecs[i].data; em = 1'b0; en = 1'b1;
        step();
      end
      chk({vecs[i].name, " pop"}, 64'(pp), 64'd1);
      chk({vecs[i].name, " start"}, 64'(tx), 64'd0);
      if (chained) chk({vecs[i].name, " pp period"}, 64'(cyc - last_pp), 64'd41);
      last_pp = cyc;
      check_frame(vecs[i]);
      chained = !vecs[i].next_em;
      if (chained) step();
    end

    // Enable gating
    em = 1'b0; din = 8'h81; en = 1'b0;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (pp !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("en gated idle", 64'(bad), 64'd0);
    en = 1'b1;
    step();
    chk("en raise pop", 64'(pp), 64'd1);
    chk("en raise start", 64'(tx), 64'd0);
    v = '{8'h81, 1'b1, 8'h00, 1'b0, 10'b1100000010, "en_raise_81"};
    check_frame(v);

    // Reset during data bit 3
    din = 8'hFF; em = 1'b0;
    step();
    chk("rstmid pop", 64'(pp), 64'd1);
    em = 1'b1;
    for (int k = 0; k < 17; k++) step();
    chk("rstmid bit3", 64'(tx), 64'd1);
    chk("rstmid busy before", 64'(busy), 64'd1);
    rst = 1'b0;
    step();
    chk("rstmid tx", 64'(tx), 64'd1);
    chk("rstmid busy", 64'(busy), 64'd0);
    chk("rstmid pp", 64'(pp), 64'd0);
    step(); step();
    rst = 1'b1; din = 8'h5A; em = 1'b0;
    step();
    chk("rstmid fresh pop", 64'(pp), 64'd1);
    v = '{8'h5A, 1'b1, 8'h00, 1'b0, 10'b1010110100, "after_rst_5A"};
    check_frame(v);

    // Reset landing in the pop cycle
    din = 8'h33; em = 1'b0;
    step();
    chk("rstpp pop", 64'(pp), 64'd1);
    rst = 1'b0; em = 1'b1;
    step();
    chk("rstpp pp", 64'(pp), 64'd0);
    chk("rstpp tx", 64'(tx), 64'd1);
    chk("rstpp busy", 64'(busy), 64'd0);
    rst = 1'b1;
    step(); step();
    chk("rstpp stays idle", 64'({tx, pp, busy}), 64'b100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
